// File: rtl/raccoon_player_if.sv
// Player controller bus: debounced buttons, collision and restart in;
// sprite position, level, lives and state out.
interface raccoon_player_if;
   logic       i_Raccoon_Up;
   logic       i_Raccoon_Dn;
   logic       i_Raccoon_Lt;
   logic       i_Raccoon_Rt;
   logic       i_Collision;
   logic       i_Start;
   logic [9:0] o_Raccoon_X;
   logic [9:0] o_Raccoon_Y;
   logic [3:0] o_Level;
   logic [2:0] o_Lives;
   logic [1:0] o_State;
   logic       o_Game_Over;

   modport master (
      output i_Raccoon_Up, i_Raccoon_Dn, i_Raccoon_Lt, i_Raccoon_Rt, i_Collision, i_Start,
      input  o_Raccoon_X, o_Raccoon_Y, o_Level, o_Lives, o_State, o_Game_Over
   );

   modport slave (
      input  i_Raccoon_Up, i_Raccoon_Dn, i_Raccoon_Lt, i_Raccoon_Rt, i_Collision, i_Start,
      output o_Raccoon_X, o_Raccoon_Y, o_Level, o_Lives, o_State, o_Game_Over
   );
endinterface

// File: rtl/raccoon_player_fsm.sv
// Raccoon crossing player controller: grid moves on a tick, lives/level, HIT/WIN pauses.
// Optional feature macro RACCOON_AUTOREPEAT_EN: held buttons auto-repeat every REPEAT_TICKS ticks.
module raccoon_player_fsm #(
   parameter int GAME_WIDTH    = 640,
   parameter int GAME_HEIGHT   = 480,
   parameter int GRID_WIDTH    = 32,
   parameter int GRID_HEIGHT   = 32,
   parameter int PLAYER_WIDTH  = 32,
   parameter int PLAYER_HEIGHT = 32,
   parameter int MAX_LEVEL     = 9,
   parameter int LIVES         = 3,
   parameter int TICK_DIV      = 1250000,
   parameter int PAUSE_TICKS   = 20,
   parameter int REPEAT_TICKS  = 4
) (
   input logic             i_Clk,
   input logic             i_Rst_n,
   raccoon_player_if.slave bus
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PAU_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TICK_DIV - 1);
   localparam logic [PAU_W-1:0] PAU_MAX    = PAU_W'(PAUSE_TICKS - 1);
   localparam logic [9:0]       X0         = 10'((GAME_WIDTH / 2) / GRID_WIDTH * GRID_WIDTH);
   localparam logic [9:0]       Y0         = 10'((GAME_HEIGHT - PLAYER_HEIGHT) / GRID_HEIGHT * GRID_HEIGHT);
   localparam logic [10:0]      STEP_X     = 11'(GRID_WIDTH);
   localparam logic [10:0]      STEP_Y     = 11'(GRID_HEIGHT);
   localparam logic [10:0]      X_LIM      = 11'(GAME_WIDTH - PLAYER_WIDTH);
   localparam logic [10:0]      Y_LIM      = 11'(GAME_HEIGHT - PLAYER_HEIGHT);
   localparam logic [3:0]       LVL_MAX    = 4'(MAX_LEVEL);
   localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
   localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3;

   if (MAX_LEVEL < 1 || MAX_LEVEL > 15 || LIVES < 1 || LIVES > 7 ||
       TICK_DIV < 2 || PAUSE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("raccoon_player_fsm: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_HIT  = 2'd1,
      ST_WIN  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [9:0]       x_q, x_d, y_q, y_d;
   logic [3:0]       level_q, level_d;
   logic [2:0]       lives_q, lives_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [PAU_W-1:0] pause_q, pause_d;
   logic [3:0]       btn_prev_q, pend_q, pend_d;
   logic [3:0]       btn, rise, req, rep_fire;
   logic             tick;

   assign btn  = {bus.i_Raccoon_Rt, bus.i_Raccoon_Lt, bus.i_Raccoon_Dn, bus.i_Raccoon_Up};
   assign rise = btn & ~btn_prev_q;
   assign tick = (tick_cnt_q == CNT_MAX);
   // A press landing on the tick clock itself still counts for that tick.
   assign req  = pend_q | rise | rep_fire;

`ifdef RACCOON_AUTOREPEAT_EN
   localparam int RPT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_TICKS - 1);

   logic [3:0]            rep_act_q, rep_act_d;
   logic [3:0][RPT_W-1:0] rep_cnt_q, rep_cnt_d;

   always_comb begin
      rep_fire = '0;
      for (int b = 0; b < 4; b++) begin
         rep_fire[b] = tick && (state_q == ST_PLAY) && rep_act_q[b] && btn[b] &&
                       (rep_cnt_q[b] == RPT_MAX);
      end
   end

   // Counting restarts on every step the button requests, so steps land REPEAT_TICKS apart.
   always_comb begin
      rep_act_d = rep_act_q;
      rep_cnt_d = rep_cnt_q;
      for (int b = 0; b < 4; b++) begin
         if (!btn[b] || state_q != ST_PLAY) begin
            rep_act_d[b] = 1'b0;
            rep_cnt_d[b] = '0;
         end else if (tick) begin
            if (req[b]) begin
               rep_act_d[b] = 1'b1;
               rep_cnt_d[b] = '0;
            end else if (rep_act_q[b]) begin
               rep_cnt_d[b] = rep_cnt_q[b] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rep_act_q <= '0;
         rep_cnt_q <= '0;
      end else begin
         rep_act_q <= rep_act_d;
         rep_cnt_q <= rep_cnt_d;
      end
   end
`else
   assign rep_fire = '0;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      level_d    = level_q;
      lives_d    = lives_q;
      pause_d    = pause_q;
      pend_d     = '0;
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      unique case (state_q)
         ST_PLAY: begin
            pend_d = tick ? '0 : (pend_q | rise);
            if (bus.i_Collision) begin
               state_d = ST_HIT;
               lives_d = lives_q - 1'b1;
               pause_d = '0;
               pend_d  = '0;
            end else if (y_q == '0) begin
               state_d = ST_WIN;
               pause_d = '0;
               pend_d  = '0;
            end else if (tick) begin
               if (req[B_UP]) begin
                  if ({1'b0, y_q} >= STEP_Y) y_d = y_q - STEP_Y[9:0];
               end else if (req[B_DN]) begin
                  if ({1'b0, y_q} + STEP_Y <= Y_LIM) y_d = y_q + STEP_Y[9:0];
               end
               if (req[B_LT]) begin
                  if ({1'b0, x_q} >= STEP_X) x_d = x_q - STEP_X[9:0];
               end else if (req[B_RT]) begin
                  if ({1'b0, x_q} + STEP_X <= X_LIM) x_d = x_q + STEP_X[9:0];
               end
            end
         end
         ST_HIT, ST_WIN: begin
            if (tick) begin
               if (pause_q == PAU_MAX) begin
                  if (state_q == ST_HIT && lives_q == '0) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d = ST_PLAY;
                     x_d     = X0;
                     y_d     = Y0;
                     if (state_q == ST_WIN && level_q != LVL_MAX) level_d = level_q + 1'b1;
                  end
               end else begin
                  pause_d = pause_q + 1'b1;
               end
            end
         end
         ST_OVER: begin
            if (bus.i_Start) begin
               state_d    = ST_PLAY;
               x_d        = X0;
               y_d        = Y0;
               level_d    = 4'd1;
               lives_d    = LIVES_INIT;
               pause_d    = '0;
               tick_cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= ST_PLAY;
         x_q        <= X0;
         y_q        <= Y0;
         level_q    <= 4'd1;
         lives_q    <= LIVES_INIT;
         tick_cnt_q <= '0;
         pause_q    <= '0;
         btn_prev_q <= '0;
         pend_q     <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         level_q    <= level_d;
         lives_q    <= lives_d;
         tick_cnt_q <= tick_cnt_d;
         pause_q    <= pause_d;
         btn_prev_q <= btn;
         pend_q     <= pend_d;
      end
   end

   assign bus.o_Raccoon_X = x_q;
   assign bus.o_Raccoon_Y = y_q;
   assign bus.o_Level     = level_q;
   assign bus.o_Lives     = lives_q;
   assign bus.o_State     = state_q;
   assign bus.o_Game_Over = (state_q == ST_OVER);

endmodule

// File: tb/tb_raccoon_player_fsm.sv
// Directed bench for raccoon_player_fsm with TICK_DIV=4, PAUSE_TICKS=2 (X0=320, Y0=448).
module tb_raccoon_player_fsm;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   raccoon_player_if bus();

   raccoon_player_fsm #(
      .TICK_DIV    (4),
      .PAUSE_TICKS (2)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // b = {Rt, Lt, Dn, Up}; held for exactly one rising edge
   task automatic press(input logic [3:0] b);
      bus.i_Raccoon_Up = b[0];
      bus.i_Raccoon_Dn = b[1];
      bus.i_Raccoon_Lt = b[2];
      bus.i_Raccoon_Rt = b[3];
      clks(1);
      bus.i_Raccoon_Up = 1'b0;
      bus.i_Raccoon_Dn = 1'b0;
      bus.i_Raccoon_Lt = 1'b0;
      bus.i_Raccoon_Rt = 1'b0;
   endtask

   // one press followed by a full tick period, so exactly one tick consumes it
   task automatic move(input logic [3:0] b);
      press(b);
      clks(4);
   endtask

   task automatic collide();
      bus.i_Collision = 1'b1;
      clks(1);
      bus.i_Collision = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n            = 1'b0;
      bus.i_Raccoon_Up = 1'b0;
      bus.i_Raccoon_Dn = 1'b0;
      bus.i_Raccoon_Lt = 1'b0;
      bus.i_Raccoon_Rt = 1'b0;
      bus.i_Collision  = 1'b0;
      bus.i_Start      = 1'b0;
      clks(2);
      rst_n = 1'b1;

      chk("rst_x", bus.o_Raccoon_X, 320);
      chk("rst_y", bus.o_Raccoon_Y, 448);
      chk("rst_level", bus.o_Level, 1);
      chk("rst_lives", bus.o_Lives, 3);
      chk("rst_state", bus.o_State, 0);
      chk("rst_over", bus.o_Game_Over, 0);

      move(4'b0001);
      chk("up_y", bus.o_Raccoon_Y, 416);
      chk("up_x", bus.o_Raccoon_X, 320);
      chk("up_state", bus.o_State, 0);

      bus.i_Raccoon_Lt = 1'b1;
      clks(5);
      chk("lt_first", bus.o_Raccoon_X, 288);
      clks(8);
      chk("lt_hold", bus.o_Raccoon_X, 288);
      clks(12);
`ifdef RACCOON_AUTOREPEAT_EN
      chk("lt_repeat", bus.o_Raccoon_X, 256);
`else
      chk("lt_repeat", bus.o_Raccoon_X, 288);
`endif
      bus.i_Raccoon_Lt = 1'b0;
      clks(1);

      collide();
      chk("hit_state", bus.o_State, 1);
      chk("hit_lives", bus.o_Lives, 2);
      chk("hit_freeze_y", bus.o_Raccoon_Y, 416);
      move(4'b0001);
      chk("hit_ignore_up", bus.o_Raccoon_Y, 416);
      clks(4);
      chk("hit_exit_x", bus.o_Raccoon_X, 320);
      chk("hit_exit_y", bus.o_Raccoon_Y, 448);
      chk("hit_exit_state", bus.o_State, 0);

      move(4'b0011);
      chk("up_beats_dn", bus.o_Raccoon_Y, 416);
      move(4'b0010);
      chk("dn_step", bus.o_Raccoon_Y, 448);
      move(4'b0010);
      chk("dn_bottom", bus.o_Raccoon_Y, 448);
      move(4'b1100);
      chk("lt_beats_rt", bus.o_Raccoon_X, 288);
      move(4'b1000);
      chk("rt_step", bus.o_Raccoon_X, 320);
      repeat (11) move(4'b0100);
      chk("lt_left_edge", bus.o_Raccoon_X, 0);
      repeat (10) move(4'b1000);
      chk("rt_back", bus.o_Raccoon_X, 320);

      for (int w = 0; w < 9; w++) begin
         repeat (14) move(4'b0001);
         if (w == 0) chk("arrive_y0", bus.o_Raccoon_Y, 0);
         clks(10);
         chk("win_level", bus.o_Level, (w + 2 > 9) ? 9 : w + 2);
      end
      chk("win_y", bus.o_Raccoon_Y, 448);
      chk("win_state", bus.o_State, 0);
      chk("win_lives", bus.o_Lives, 2);

      repeat (13) move(4'b0001);
      chk("near_top", bus.o_Raccoon_Y, 32);
      press(4'b0001);
      k = 0;
      while (bus.o_Raccoon_Y != 0 && k < 8) begin
         clks(1);
         k++;
      end
      chk("arrive_y0_hit", bus.o_Raccoon_Y, 0);
      collide();
      chk("arrive_hit_state", bus.o_State, 1);
      chk("arrive_hit_level", bus.o_Level, 9);
      chk("arrive_hit_lives", bus.o_Lives, 1);
      clks(8);
      chk("arrive_exit_state", bus.o_State, 0);
      chk("arrive_exit_y", bus.o_Raccoon_Y, 448);
      chk("arrive_exit_level", bus.o_Level, 9);

      collide();
      chk("last_hit_lives", bus.o_Lives, 0);
      chk("last_hit_state", bus.o_State, 1);
      clks(8);
      chk("over_state", bus.o_State, 3);
      chk("over_flag", bus.o_Game_Over, 1);
      move(4'b0101);
      clks(4);
      chk("over_hold_y", bus.o_Raccoon_Y, 448);
      chk("over_hold_x", bus.o_Raccoon_X, 320);
      chk("over_hold_state", bus.o_State, 3);
      bus.i_Start = 1'b1;
      clks(1);
      bus.i_Start = 1'b0;
      chk("start_state", bus.o_State, 0);
      chk("start_lives", bus.o_Lives, 3);
      chk("start_level", bus.o_Level, 1);
      chk("start_over", bus.o_Game_Over, 0);

      move(4'b0001);
      chk("pre_rst_y", bus.o_Raccoon_Y, 416);
      collide();
      chk("pre_rst_state", bus.o_State, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_state", bus.o_State, 0);
      chk("async_rst_y", bus.o_Raccoon_Y, 448);
      chk("async_rst_lives", bus.o_Lives, 3);
      clks(1);
      rst_n = 1'b1;
      clks(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
